// File: rtl/rand_pkg.sv
// Shared definitions for the LFSR-based random sources: draw FSM states,
// known-good tap masks and the lock-up pattern helper.
package rand_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    DRAW = 1'b1
  } draw_state_e;

  // Maximal-length XNOR tap masks for common register widths.
  localparam logic [2:0]  TAPS_W3  = 3'b110;
  localparam logic [7:0]  TAPS_W8  = 8'hB8;
  localparam logic [15:0] TAPS_W16 = 16'hB400;

  // All-ones is the XNOR lock-up state; returned right-aligned for a given width.
  function automatic logic [63:0] lockup_value(input int width);
    lockup_value = {64{1'b1}} >> (64 - width);
  endfunction

endpackage

// File: rtl/lfsr_step.sv
// Combinational single step of an XNOR-feedback Fibonacci LFSR.
module lfsr_step
  import rand_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = TAPS_W8
) (
  input  logic [WIDTH-1:0] state_i,
  output logic [WIDTH-1:0] next_o
);

  logic fb;

  assign fb     = ~^(state_i & TAPS);
  assign next_o = {state_i[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr_rand.sv
// Free-running LFSR with a clock-enable prescaler plus on-demand bounded
// draws in [0, RANGE-1] using rejection sampling with a fold-down fallback.
module lfsr_rand
  import rand_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] TAPS     = TAPS_W8,
  parameter logic [WIDTH-1:0] SEED_RST = {WIDTH{1'b0}},
  parameter int               DIV      = 2,
  parameter int               OUT_W    = 3,
  parameter int               RANGE    = 6
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             active_i,
  input  logic             enable_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             draw_req_i,
  output logic             draw_valid_o,
  output logic [OUT_W-1:0] draw_value_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] state_o,
  output logic             step_o
);

  localparam int               PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int               RW         = OUT_W + 1;
  localparam logic [PW-1:0]    PRE_LAST   = PW'(DIV - 1);
  localparam logic [PW-1:0]    PRE_ONE    = PW'(1);
  localparam logic [RW-1:0]    RANGE_W    = RW'(RANGE);
  localparam logic [OUT_W-1:0] RANGE_LO   = OUT_W'(RANGE);
  localparam logic [OUT_W-1:0] TRIES_LAST = {OUT_W{1'b1}};
  localparam logic [OUT_W-1:0] TRY_ONE    = OUT_W'(1);
  localparam logic [WIDTH-1:0] LOCKUP     = WIDTH'(lockup_value(WIDTH));

  logic [WIDTH-1:0] state_q, state_d;
  logic [PW-1:0]    pre_q, pre_d;
  draw_state_e      fsm_q, fsm_d;
  logic [OUT_W-1:0] tries_q, tries_d;
  logic             dv_q, dv_d;
  logic [OUT_W-1:0] val_q, val_d;
  logic             step_q, step_d;

  logic [WIDTH-1:0] lfsr_next_s;
  logic [OUT_W-1:0] cand_s;
  logic             cand_ok_s;

  lfsr_step #(
    .WIDTH(WIDTH),
    .TAPS (TAPS)
  ) u_step (
    .state_i(state_q),
    .next_o (lfsr_next_s)
  );

  assign cand_s    = state_q[OUT_W-1:0];
  assign cand_ok_s = ({1'b0, cand_s} < RANGE_W);

  // Next-state: clear, seed, draw sequencing and prescaled free-run stepping.
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    fsm_d   = fsm_q;
    tries_d = tries_q;
    dv_d    = 1'b0;
    val_d   = val_q;
    step_d  = 1'b0;

    if (!active_i) begin
      state_d = SEED_RST;
      pre_d   = {PW{1'b0}};
      fsm_d   = IDLE;
      tries_d = {OUT_W{1'b0}};
    end else if (seed_load_i) begin
      // Lock-up seed is replaced by zero; a pending draw resumes from here.
      state_d = (seed_i == LOCKUP) ? {WIDTH{1'b0}} : seed_i;
      pre_d   = {PW{1'b0}};
    end else begin
      case (fsm_q)
        IDLE: begin
          if (draw_req_i) begin
            state_d = lfsr_next_s;
            step_d  = 1'b1;
            if (cand_ok_s) begin
              val_d = cand_s;
              dv_d  = 1'b1;
            end else begin
              fsm_d   = DRAW;
              tries_d = TRY_ONE;
            end
          end else if (enable_i) begin
            if (pre_q == PRE_LAST) begin
              pre_d   = {PW{1'b0}};
              state_d = lfsr_next_s;
              step_d  = 1'b1;
            end else begin
              pre_d = pre_q + PRE_ONE;
            end
          end else begin
            pre_d = pre_q;
          end
        end
        DRAW: begin
          state_d = lfsr_next_s;
          step_d  = 1'b1;
          if (cand_ok_s) begin
            val_d   = cand_s;
            dv_d    = 1'b1;
            fsm_d   = IDLE;
            tries_d = {OUT_W{1'b0}};
          end else if (tries_q == TRIES_LAST) begin
            // Out of attempts: fold the candidate down; it is always < RANGE.
            val_d   = cand_s - RANGE_LO;
            dv_d    = 1'b1;
            fsm_d   = IDLE;
            tries_d = {OUT_W{1'b0}};
          end else begin
            tries_d = tries_q + TRY_ONE;
          end
        end
        default: begin
          fsm_d   = IDLE;
          tries_d = {OUT_W{1'b0}};
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= SEED_RST;
      pre_q   <= {PW{1'b0}};
      fsm_q   <= IDLE;
      tries_q <= {OUT_W{1'b0}};
      dv_q    <= 1'b0;
      val_q   <= {OUT_W{1'b0}};
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      fsm_q   <= fsm_d;
      tries_q <= tries_d;
      dv_q    <= dv_d;
      val_q   <= val_d;
      step_q  <= step_d;
    end
  end

  assign draw_valid_o = dv_q;
  assign draw_value_o = val_q;
  assign busy_o       = (fsm_q == DRAW);
  assign state_o      = state_q;
  assign step_o       = step_q;

endmodule
